// File: rtl/reg_ctx_seq_pkg.sv
// Shared definitions for the register context save/restore sequencer.
package reg_ctx_seq_pkg;

    localparam int DEF_N         = 16;
    localparam int DEF_REG_COUNT = 8;
    localparam int DEF_ADDR_SIZE = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SAVE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_ctx_seq.sv
// Sequencer that copies a register block to memory (save) or reloads it
// from memory (restore), one register per memory handshake.
module reg_ctx_seq
    import reg_ctx_seq_pkg::*;
#(
    parameter int n         = DEF_N,
    parameter int reg_count = DEF_REG_COUNT,
    parameter int addr_size = DEF_ADDR_SIZE
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 StartSave,
    input  logic                 StartRestore,
    input  logic [n-1:0]         Base,
    output logic                 Busy,
    output logic                 Done,
    output logic [addr_size-1:0] Rs,
    input  logic [n-1:0]         Rd,
    output logic [addr_size-1:0] Rw,
    output logic                 We,
    output logic [n-1:0]         WData,
    output logic [n-1:0]         MemAddr,
    output logic [n-1:0]         MemWData,
    output logic                 MemWe,
    output logic                 MemRe,
    input  logic [n-1:0]         MemRData,
    input  logic                 MemAck,
    output state_t               dbg_state
);

    // Handshake: MemWe/MemRe stay high with stable MemAddr/MemWData until a
    // posedge where MemAck is sampled high; that edge completes the transfer.

    localparam logic [addr_size-1:0] LAST_IDX = addr_size'(reg_count - 1);

    state_t               state;
    state_t               state_next;
    logic [addr_size-1:0] index;
    logic [n-1:0]         base_q;
    logic [n-1:0]         cap_q;
    logic                 last;
    logic                 start_any;
    logic [n-1:0]         mem_addr;

    assign last      = (index == LAST_IDX);
    assign start_any = StartSave | StartRestore;
    // Address arithmetic wraps naturally at n bits.
    assign mem_addr  = base_q + n'(index);
    assign dbg_state = state;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (StartSave) begin
                    state_next = ST_SAVE;
                end else if (StartRestore) begin
                    state_next = ST_LOAD;
                end
            end
            ST_SAVE: begin
                if (MemAck && last) begin
                    state_next = ST_DONE;
                end
            end
            ST_LOAD: begin
                if (MemAck) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = last ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        Busy     = (state != ST_IDLE);
        Done     = 1'b0;
        Rs       = '0;
        Rw       = '0;
        We       = 1'b0;
        WData    = '0;
        MemAddr  = '0;
        MemWData = '0;
        MemWe    = 1'b0;
        MemRe    = 1'b0;
        case (state)
            ST_SAVE: begin
                Rs       = index;
                MemWe    = 1'b1;
                MemAddr  = mem_addr;
                MemWData = Rd;
            end
            ST_LOAD: begin
                MemRe   = 1'b1;
                MemAddr = mem_addr;
            end
            ST_WRITE: begin
                We    = 1'b1;
                Rw    = index;
                WData = cap_q;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Index, latched base and captured read data.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            index  <= '0;
            base_q <= '0;
            cap_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_any) begin
                        base_q <= Base;
                        index  <= '0;
                    end
                end
                ST_SAVE: begin
                    if (MemAck && !last) begin
                        index <= index + addr_size'(1);
                    end
                end
                ST_LOAD: begin
                    if (MemAck) begin
                        cap_q <= MemRData;
                    end
                end
                ST_WRITE: begin
                    if (!last) begin
                        index <= index + addr_size'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/reg_ctx_seq.md
REG_CTX_SEQ -- requirements
Module: reg_ctx_seq

Interface
REQ-001 SHALL have parameter n, default 16, data/address width.
REQ-002 SHALL have parameter reg_count, default 8, number of registers sequenced.
REQ-003 SHALL have parameter addr_size, default 3, register index width.
REQ-004 Clock  input  1  single clock; all state changes on posedge.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 StartSave  input  1  request: copy all registers to memory.
REQ-007 StartRestore  input  1  request: reload all registers from memory.
REQ-008 Base  input  n  memory base address, sampled at start.
REQ-009 Busy  output  1  high from accepted start until Done cycle inclusive.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Rs  output  addr_size  register read index to register block.
REQ-012 Rd  input  n  register read data (combinational from Rs).
REQ-013 Rw  output  addr_size  register write index.
REQ-014 We  output  1  register write enable.
REQ-015 WData  output  n  register write data.
REQ-016 MemAddr  output  n  memory address.
REQ-017 MemWData  output  n  memory write data.
REQ-018 MemWe / MemRe  output  1 each  memory write/read request, held until MemAck.
REQ-019 MemRData  input  n  memory read data, valid when MemAck high.
REQ-020 MemAck  input  1  memory completes held request at posedge where sampled high.

Function
REQ-021 States SHALL be IDLE, SAVE, LOAD, WRITE, DONE.
REQ-022 IDLE: StartSave -> SAVE; else StartRestore -> LOAD; both high -> SAVE (save wins); Base latched, index cleared to 0.
REQ-023 Start inputs outside IDLE SHALL be ignored (no queueing).
REQ-024 SAVE: Rs=index, MemWe=1, MemAddr=BaseLatched+index, MemWData=Rd; on MemAck index increments; at MemAck with index=reg_count-1 -> DONE.
REQ-025 LOAD: MemRe=1, MemAddr=BaseLatched+index; on MemAck capture MemRData -> WRITE.
REQ-026 WRITE: exactly one cycle, We=1, Rw=index, WData=captured data; index=reg_count-1 -> DONE, else index increments -> LOAD.
REQ-027 DONE: Done=1, Busy=1 for one cycle -> IDLE; start in DONE cycle ignored.
REQ-028 Minimum latency with MemAck held high: save reg_count+1 cycles, restore 2*reg_count+1 cycles, start-accept edge to Done deassert.
REQ-029 MemAddr addition SHALL wrap modulo 2^n; index zero-extended to n bits.
REQ-030 MemWe, MemRe, We SHALL be mutually exclusive and never high in IDLE or DONE.
REQ-031 MemAck outside SAVE/LOAD SHALL be ignored; MemAddr/MemWData stable while request held.
REQ-032 Busy SHALL be low only in IDLE.

Reset
REQ-033 nReset low SHALL immediately force IDLE, index 0, Busy/Done/We/MemWe/MemRe 0, all address/data outputs 0, including mid-sequence.
REQ-034 After reset release, first start SHALL be accepted on the first posedge with nReset high.

Structure
REQ-035 Shared package SHALL hold the state enum typedef and default n/reg_count/addr_size constants.
REQ-036 No sub-module; single FSM plus index counter and data capture register; bench instantiates the existing register block.

Verification
REQ-037 Regs preloaded 0x1000+i, Base=0x0040, StartSave, MemAck always 1 -> writes 0x0040..0x0047 with 0x1000..0x1007, Done at cycle 9.
REQ-038 Memory 0x0080+i holds 0xA0A0+i, StartRestore, MemAck delayed 2 cycles each -> regs 0..7 = 0xA0A0..0xA0A7, one We pulse per reg.
REQ-039 StartSave and StartRestore same cycle -> save sequence only; StartSave during Busy -> no restart.
REQ-040 Base=0xFFFE save -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005.
REQ-041 nReset low during restore index 3 -> outputs zero same time step, regs 3..7 unchanged, new save after release completes normally.
